// File: rtl/bm_pkg.sv
// Shared constants and types for the block-matching pipeline
// (block_min_select, block_popcount, xors_to_stream).
package bm_pkg;

  localparam int BLK_W    = 16;
  localparam int BLK_H    = 16;
  localparam int NUM_CAND = 64;

  localparam int COST_W = $clog2(BLK_W * BLK_H + 1);
  localparam int ROW_W  = $clog2(BLK_W + 1);

  typedef logic [COST_W-1:0]            cost_t;
  typedef logic [ROW_W-1:0]             row_cnt_t;
  typedef logic [BLK_H-1:0][BLK_W-1:0] xor_blk_t;

  localparam cost_t COST_MAX = {COST_W{1'b1}};

  // Clamp a cost difference to the largest value a conf_w-bit field can hold.
  function automatic cost_t sat_conf(input cost_t diff, input int conf_w);
    cost_t lim;
    if (conf_w >= COST_W) begin
      lim = COST_MAX;
    end else begin
      lim = cost_t'((32'd1 << conf_w) - 32'd1);
    end
    if (diff > lim) begin
      return lim;
    end else begin
      return diff;
    end
  endfunction

endpackage

// File: rtl/block_min_select_if.sv
// Candidate input and result output bundle of block_min_select; the result
// side matches what xors_to_stream consumes.
interface block_min_select_if #(
  parameter int COORD_W = 8,
  parameter int CONF_W  = 8
);
  import bm_pkg::*;

  xor_blk_t            cand_xors;
  logic                cand_valid;
  logic                cand_first;
  logic                cand_last;
  xor_blk_t            xors_out;
  logic                xors_valid;
  logic [COORD_W-1:0]  min_coords;
  logic [CONF_W-1:0]   confidence;
  logic                protocol_err;

  modport master (
    output cand_xors, cand_valid, cand_first, cand_last,
    input  xors_out, xors_valid, min_coords, confidence, protocol_err
  );

  modport slave (
    input  cand_xors, cand_valid, cand_first, cand_last,
    output xors_out, xors_valid, min_coords, confidence, protocol_err
  );

endinterface

// File: rtl/block_popcount.sv
// Two-stage pipelined popcount of one XOR block: stage 1 registers per-row
// counts, stage 2 registers their sum.
module block_popcount
  import bm_pkg::*;
(
  input  logic     clk_i,
  input  logic     reset_i,
  input  xor_blk_t blk_i,
  input  logic     valid_i,
  output cost_t    cost_o,
  output logic     valid_o
);

  row_cnt_t [BLK_H-1:0] row_cnt_d;
  row_cnt_t [BLK_H-1:0] row_cnt_q;
  cost_t                cost_d;
  cost_t                cost_q;
  logic                 s1_valid_q;
  logic                 s2_valid_q;

  // Per-row bit count of the incoming block.
  always_comb begin
    row_cnt_d = '0;
    for (int r = 0; r < BLK_H; r++) begin
      for (int c = 0; c < BLK_W; c++) begin
        row_cnt_d[r] = row_cnt_d[r] + row_cnt_t'(blk_i[r][c]);
      end
    end
  end

  // Sum of the registered row counts.
  always_comb begin
    cost_d = '0;
    for (int r = 0; r < BLK_H; r++) begin
      cost_d = cost_d + cost_t'(row_cnt_q[r]);
    end
  end

  // Stage registers and valid tracking.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      row_cnt_q  <= '0;
      cost_q     <= '0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      row_cnt_q  <= row_cnt_d;
      cost_q     <= cost_d;
      s1_valid_q <= valid_i;
      s2_valid_q <= s1_valid_q;
    end
  end

  assign cost_o  = cost_q;
  assign valid_o = s2_valid_q;

endmodule

// File: rtl/block_min_select.sv
// Tracks the minimum and second-minimum Hamming cost over a disparity search
// and emits the winning XOR block, its index and a saturated confidence.
module block_min_select
  import bm_pkg::*;
#(
  parameter int COORD_W = 8,
  parameter int CONF_W  = 8
) (
  input logic               clk,
  input logic               reset,
  block_min_select_if.slave bus
);

  localparam int CNT_W = $clog2(NUM_CAND + 1);

  // Framing and index state
  logic               open_q, open_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               acc_s, acc_first_s, acc_last_s, acc_upd_s, err_set_s;
  logic [COORD_W-1:0] acc_idx_s;

  // Sideband travelling alongside the popcount stages
  xor_blk_t           s1_xors_q, s2_xors_q;
  logic [COORD_W-1:0] s1_idx_q, s2_idx_q;
  logic               s1_first_q, s2_first_q;
  logic               s1_last_q, s2_last_q;
  logic               s1_upd_q, s2_upd_q;
  cost_t              s2_cost_s;
  logic               s2_valid_s;

  // S3 compare state and registered outputs
  cost_t              best_cost_q, best_cost_d;
  cost_t              second_cost_q, second_cost_d;
  xor_blk_t           best_xors_q, best_xors_d;
  logic [COORD_W-1:0] best_idx_q, best_idx_d;
  xor_blk_t           xors_out_q;
  logic               xors_valid_q;
  logic [COORD_W-1:0] min_coords_q;
  logic [CONF_W-1:0]  conf_q;
  logic               err_q;

  // Accept/drop decision and index assignment for the incoming candidate.
  always_comb begin
    open_d      = open_q;
    cnt_d       = cnt_q;
    acc_s       = 1'b0;
    acc_first_s = 1'b0;
    acc_last_s  = 1'b0;
    acc_upd_s   = 1'b0;
    acc_idx_s   = '0;
    err_set_s   = 1'b0;
    if (bus.cand_valid) begin
      if (bus.cand_first) begin
        acc_s       = 1'b1;
        acc_first_s = 1'b1;
        acc_upd_s   = 1'b1;
        acc_last_s  = bus.cand_last;
        err_set_s   = open_q;
        open_d      = ~bus.cand_last;
        cnt_d       = CNT_W'(1);
      end else if (!open_q) begin
        err_set_s = 1'b1;
      end else if (cnt_q == CNT_W'(NUM_CAND)) begin
        // Over-length: compare nothing more, but a closing candidate still
        // has to flush the result of the first NUM_CAND candidates.
        err_set_s = 1'b1;
        if (bus.cand_last) begin
          acc_s      = 1'b1;
          acc_last_s = 1'b1;
          open_d     = 1'b0;
        end else begin
          acc_s = 1'b0;
        end
      end else begin
        acc_s      = 1'b1;
        acc_upd_s  = 1'b1;
        acc_last_s = bus.cand_last;
        acc_idx_s  = COORD_W'(cnt_q);
        cnt_d      = cnt_q + CNT_W'(1);
        open_d     = ~bus.cand_last;
      end
    end else begin
      acc_s = 1'b0;
    end
  end

  block_popcount u_popcount (
    .clk_i   (clk),
    .reset_i (reset),
    .blk_i   (bus.cand_xors),
    .valid_i (acc_s),
    .cost_o  (s2_cost_s),
    .valid_o (s2_valid_s)
  );

  // Framing state and sideband pipeline registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      open_q     <= 1'b0;
      cnt_q      <= '0;
      s1_xors_q  <= '0;
      s1_idx_q   <= '0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_upd_q   <= 1'b0;
      s2_xors_q  <= '0;
      s2_idx_q   <= '0;
      s2_first_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_upd_q   <= 1'b0;
    end else begin
      open_q     <= open_d;
      cnt_q      <= cnt_d;
      s1_xors_q  <= bus.cand_xors;
      s1_idx_q   <= acc_idx_s;
      s1_first_q <= acc_first_s;
      s1_last_q  <= acc_last_s;
      s1_upd_q   <= acc_upd_s;
      s2_xors_q  <= s1_xors_q;
      s2_idx_q   <= s1_idx_q;
      s2_first_q <= s1_first_q;
      s2_last_q  <= s1_last_q;
      s2_upd_q   <= s1_upd_q;
    end
  end

  // Min / second-min update; strict less-than keeps the lowest index on ties.
  always_comb begin
    best_cost_d   = best_cost_q;
    second_cost_d = second_cost_q;
    best_xors_d   = best_xors_q;
    best_idx_d    = best_idx_q;
    if (s2_valid_s && s2_upd_q) begin
      if (s2_first_q) begin
        best_cost_d   = s2_cost_s;
        second_cost_d = COST_MAX;
        best_xors_d   = s2_xors_q;
        best_idx_d    = s2_idx_q;
      end else if (s2_cost_s < best_cost_q) begin
        second_cost_d = best_cost_q;
        best_cost_d   = s2_cost_s;
        best_xors_d   = s2_xors_q;
        best_idx_d    = s2_idx_q;
      end else if (s2_cost_s < second_cost_q) begin
        second_cost_d = s2_cost_s;
      end else begin
        second_cost_d = second_cost_q;
      end
    end else begin
      best_cost_d = best_cost_q;
    end
  end

  // S3 state, result registers and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      best_cost_q   <= '0;
      second_cost_q <= '0;
      best_xors_q   <= '0;
      best_idx_q    <= '0;
      xors_out_q    <= '0;
      xors_valid_q  <= 1'b0;
      min_coords_q  <= '0;
      conf_q        <= '0;
      err_q         <= 1'b0;
    end else begin
      best_cost_q   <= best_cost_d;
      second_cost_q <= second_cost_d;
      best_xors_q   <= best_xors_d;
      best_idx_q    <= best_idx_d;
      err_q         <= err_q | err_set_s;
      xors_valid_q  <= s2_valid_s & s2_last_q;
      if (s2_valid_s && s2_last_q) begin
        xors_out_q   <= best_xors_d;
        min_coords_q <= best_idx_d;
        conf_q       <= CONF_W'(sat_conf(second_cost_d - best_cost_d, CONF_W));
      end
    end
  end

  assign bus.xors_out     = xors_out_q;
  assign bus.xors_valid   = xors_valid_q;
  assign bus.min_coords   = min_coords_q;
  assign bus.confidence   = conf_q;
  assign bus.protocol_err = err_q;

endmodule

// File: tb/tb_block_min_select.sv
// Testbench for block_min_select: table vectors, random searches against a
// reference model, and hand-written framing/reset sequences.
module tb_block_min_select;
  import bm_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  block_min_select_if #(.COORD_W(8), .CONF_W(8)) bus ();
  block_min_select #(.COORD_W(8), .CONF_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef xor_blk_t blk_arr_t [NUM_CAND];
  typedef struct { int coords; int conf; xor_blk_t xors; } res_t;
  typedef struct { int cyc; int coords; int conf; xor_blk_t xors; } pulse_t;
  typedef struct { string name; int kind; int n; int exp_coords; int exp_conf; } vec_t;

  pulse_t pulses[$];
  int cyc = 0;
  int checks = 0;
  int failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.xors_valid === 1'b1) begin
      pulse_t p;
      p.cyc    = cyc;
      p.coords = int'(bus.min_coords);
      p.conf   = int'(bus.confidence);
      p.xors   = bus.xors_out;
      pulses.push_back(p);
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_blk(input string name, input xor_blk_t act, input xor_blk_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cand_valid = 1'b0;
    bus.cand_first = 1'b0;
    bus.cand_last  = 1'b0;
    bus.cand_xors  = '0;
  endtask

  task automatic drive(input xor_blk_t b, input logic f, input logic l);
    bus.cand_xors  = b;
    bus.cand_valid = 1'b1;
    bus.cand_first = f;
    bus.cand_last  = l;
    step();
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    step();
    pulses.delete();
  endtask

  function automatic xor_blk_t make_blk(input int n);
    xor_blk_t b;
    b = '0;
    if (n >= BLK_W * BLK_H) return '1;
    while ($countones(b) < n)
      b[$urandom_range(BLK_H - 1, 0)][$urandom_range(BLK_W - 1, 0)] = 1'b1;
    return b;
  endfunction

  // Reference: lowest-index minimum, second = smallest cost among all the others.
  function automatic res_t ref_model(input blk_arr_t a, input int n);
    res_t r;
    int best, bi, second, c;
    best = 1 << 30;
    bi = 0;
    for (int k = 0; k < n; k++) begin
      c = $countones(a[k]);
      if (c < best) begin best = c; bi = k; end
    end
    second = -1;
    for (int k = 0; k < n; k++) begin
      c = $countones(a[k]);
      if (k != bi && (second < 0 || c < second)) second = c;
    end
    r.coords = bi;
    r.xors   = a[bi];
    if (second < 0 || second - best > 255) r.conf = 255;
    else r.conf = second - best;
    return r;
  endfunction

  task automatic drive_search(input blk_arr_t a, input int n, output int last_cyc);
    last_cyc = 0;
    for (int k = 0; k < n; k++) begin
      if (k == n - 1) last_cyc = cyc;
      drive(a[k], k == 0, k == n - 1);
    end
    idle_inputs();
  endtask

  task automatic expect_result(input string name, input res_t e, input int last_cyc);
    repeat (6) step();
    check({name, " pulses"}, pulses.size(), 1);
    if (pulses.size() >= 1) begin
      check({name, " latency"}, pulses[0].cyc - last_cyc, 3);
      check({name, " coords"}, pulses[0].coords, e.coords);
      check({name, " conf"}, pulses[0].conf, e.conf);
      check_blk({name, " xors"}, pulses[0].xors, e.xors);
    end
    check({name, " hold coords"}, bus.min_coords, e.coords);
    check({name, " hold conf"}, bus.confidence, e.conf);
    pulses.delete();
  endtask

  task automatic fill(input int kind, output blk_arr_t a);
    for (int k = 0; k < NUM_CAND; k++) begin
      case (kind)
        0: a[k] = make_blk(k == 37 ? 3 : (k == 0 ? 20 : k + 10));
        1: a[k] = '0;
        2: a[k] = make_blk(100);
        3: a[k] = (k == 9) ? xor_blk_t'(0) : make_blk(256);
        default: a[k] = '0;
      endcase
    end
  endtask

  vec_t     vecs [4];
  blk_arr_t a, b;
  res_t     e;
  int       lc, lc2, n;

  initial begin
    vecs[0] = '{"ramp37", 0, 64, 37, 8};
    vecs[1] = '{"allzero", 1, 64, 0, 0};
    vecs[2] = '{"single", 2, 1, 0, 255};
    vecs[3] = '{"satur", 3, 64, 9, 255};

    reset = 1'b1;
    idle_inputs();
    repeat (3) step();
    check("reset xors_valid", bus.xors_valid, 0);
    check("reset min_coords", bus.min_coords, 0);
    check("reset confidence", bus.confidence, 0);
    check("reset protocol_err", bus.protocol_err, 0);
    check_blk("reset xors_out", bus.xors_out, '0);
    reset = 1'b0;
    step();

    for (int v = 0; v < 4; v++) begin
      fill(vecs[v].kind, a);
      drive_search(a, vecs[v].n, lc);
      e.coords = vecs[v].exp_coords;
      e.conf   = vecs[v].exp_conf;
      e.xors   = a[vecs[v].exp_coords];
      expect_result(vecs[v].name, e, lc);
    end

    for (int r = 0; r < 10; r++) begin
      n = $urandom_range(NUM_CAND, 1);
      for (int k = 0; k < NUM_CAND; k++) a[k] = make_blk($urandom_range(24, 0));
      drive_search(a, n, lc);
      expect_result($sformatf("rand%0d", r), ref_model(a, n), lc);
    end
    check("legal err", bus.protocol_err, 0);

    // Back-to-back searches with zero bubble
    for (int k = 0; k < NUM_CAND; k++) begin
      a[k] = make_blk(k == 5 ? 2 : 30);
      b[k] = make_blk(k == 60 ? 1 : 30);
    end
    drive_search(a, NUM_CAND, lc);
    drive_search(b, NUM_CAND, lc2);
    repeat (6) step();
    check("b2b pulses", pulses.size(), 2);
    if (pulses.size() >= 2) begin
      check("b2b latency", pulses[0].cyc - lc, 3);
      check("b2b spacing", pulses[1].cyc - pulses[0].cyc, 64);
      check("b2b coords0", pulses[0].coords, 5);
      check("b2b coords1", pulses[1].coords, 60);
    end
    check("b2b err", bus.protocol_err, 0);
    pulses.delete();

    // cand_first re-asserted at candidate 20 abandons the open search
    for (int k = 0; k < NUM_CAND; k++) begin
      a[k] = make_blk($urandom_range(5, 0));
      b[k] = make_blk($urandom_range(30, 8));
    end
    for (int k = 0; k < 20; k++) drive(a[k], k == 0, 1'b0);
    drive_search(b, NUM_CAND, lc);
    expect_result("abandon", ref_model(b, NUM_CAND), lc);
    check("abandon err", bus.protocol_err, 1);

    // Reset just after a closing candidate: nothing may come out
    do_reset();
    check("post-reset err", bus.protocol_err, 0);
    for (int k = 0; k < 30; k++) drive(a[k], k == 0, k == 29);
    drive(a[30], 1'b1, 1'b0);
    reset = 1'b1;
    idle_inputs();
    step();
    reset = 1'b0;
    repeat (8) step();
    check("reset pulses", pulses.size(), 0);
    check("reset err", bus.protocol_err, 0);
    pulses.delete();

    // Candidate without cand_first while idle is dropped
    drive(a[0], 1'b0, 1'b1);
    idle_inputs();
    repeat (6) step();
    check("idle drop pulses", pulses.size(), 0);
    check("idle drop err", bus.protocol_err, 1);
    do_reset();

    // Over-length search: extra candidates must not win
    for (int k = 0; k < NUM_CAND; k++) a[k] = make_blk($urandom_range(30, 10));
    for (int k = 0; k < NUM_CAND; k++) drive(a[k], k == 0, 1'b0);
    drive('0, 1'b0, 1'b0);
    lc = cyc;
    drive('0, 1'b0, 1'b1);
    idle_inputs();
    expect_result("overlen", ref_model(a, NUM_CAND), lc);
    check("overlen err", bus.protocol_err, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/block_min_select.md
Name: block_min_select

Overview:
- Upstream neighbour of xors_to_stream in the block-matching pipeline.
- Accepts one candidate XOR block per cycle: the left block XOR the right block at one disparity, BLK_H x BLK_W bits.
- Computes each candidate's Hamming cost and tracks the minimum and second minimum over a search.
- At search end, emits the winning XOR block, its disparity index and a confidence value in exactly the form xors_to_stream consumes (xors_in, xors_valid, min_coords, confidence).

Parameters:
- BLK_W, 16, block width in pixels (bits per row).
- BLK_H, 16, block height in rows.
- NUM_CAND, 64, maximum candidates (disparities) per search.
- COORD_W, 8, width of min_coords; must satisfy 2**COORD_W >= NUM_CAND.
- CONF_W, 8, width of confidence.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cand_xors  in  [BLK_H-1:0][BLK_W-1:0]  candidate XOR block.
- cand_valid  in  1  cand_xors is valid this cycle.
- cand_first  in  1  first candidate of a search; qualified by cand_valid.
- cand_last  in  1  last candidate of a search; qualified by cand_valid.
- xors_out  out  [BLK_H-1:0][BLK_W-1:0]  XOR block of the winning candidate.
- xors_valid  out  1  single-cycle pulse; all outputs valid.
- min_coords  out  COORD_W  index of the winner within the search (0 = first candidate).
- confidence  out  CONF_W  second-minimum cost minus minimum cost, saturated.
- protocol_err  out  1  sticky flag for a framing violation; cleared only by reset.

Behaviour:
- Reset: all outputs 0; search state idle; pipeline valid bits cleared. Reset mid-search discards the search with no output pulse.
- Cost = popcount(cand_xors), width $clog2(BLK_W*BLK_H+1) = 9 bits for the defaults (range 0..256).
- Pipeline stages:
  - S1 registers per-row popcounts.
  - S2 registers the row sum.
  - S3 holds the compare/update registers.
  - cand_xors, candidate index, first and last tags travel alongside the cost.
- Latency: candidate with cand_last accepted in cycle t gives xors_valid high in cycle t+3, for exactly one cycle.
- No backpressure; the downstream FIFO must absorb the results.
- Index counter: cleared to 0 on cand_first and incremented after each accepted candidate; the index is tagged at S1.
- S3 update on a tagged-first candidate: best_cost = cost, second_cost = MAX (all ones), best_xors and best_idx loaded.
- S3 update on any other candidate:
  - If cost < best_cost: second_cost = best_cost, then best is replaced.
  - Else if cost < second_cost: second_cost = cost.
- Tie rule: strict less-than, so the lowest index wins ties. An equal cost updates second_cost, which gives confidence 0.
- On the tagged-last candidate: outputs are loaded from the post-update best values, with confidence = min(second_cost - best_cost, 2**CONF_W - 1).
- Single-candidate search (first and last in the same cycle): confidence = 2**CONF_W - 1.
- Back-to-back searches: cand_first in cycle t+1 after cand_last in cycle t is legal, with zero bubble.
- Framing violations (each sets protocol_err):
  - cand_valid without cand_first while idle: candidate dropped.
  - cand_first while a search is open: the old search is abandoned with no output, and the new search starts.
  - The NUM_CAND+1-th candidate without cand_last: candidate dropped. The search stays open until cand_last, and the result covers the first NUM_CAND candidates only.
- xors_out, min_coords and confidence hold their values between pulses.

Decomposition:
- Package bm_pkg holds:
  - BLK_W, BLK_H, NUM_CAND;
  - cost_t (9-bit cost type) and COST_MAX;
  - xor_blk_t (packed [BLK_H-1:0][BLK_W-1:0]);
  - a sat_conf function.
  - xors_to_stream shares the same constants.
- Sub-module block_popcount: a two-stage pipelined popcount of one xor_blk_t, with valid in/out. It covers S1 and S2 and is reusable by the future left-right check stage.

Test Plan:
- 64 candidates; candidate k has k+10 set bits, except index 37, which has 3 set bits and a second-best of 11 at index 1 → one pulse 3 cycles after last; min_coords=37; confidence=8; xors_out equals the candidate-37 pattern.
- All 64 candidates all-zero → min_coords=0 (tie rule); confidence=0; xors_out=0.
- Single candidate with 100 set bits (first and last together) → pulse at t+3; min_coords=0; confidence=255.
- Best cost 0 and all others 256 (all ones) → confidence saturates at 255.
- Two back-to-back searches with no gap, winners 5 and 60 → pulses exactly 64 cycles apart with coords 5 then 60; protocol_err=0.
- cand_first re-asserted at candidate 20, and separately reset asserted at candidate 30 → abandoned search gives no pulse and protocol_err=1 (reset case: no pulse, protocol_err=0 after reset).
